// File: rtl/time_update_sched_if.sv
// rtl/time_update_sched_if.sv - read-modify-write op port between scheduler and counter datapath
interface time_update_sched_if #(
  parameter int FIELD_W = 3
);
  logic               op_valid;
  logic [FIELD_W-1:0] op_field;
  logic               op_dir;
  logic               op_wrap;

  // Scheduler side issues ops and listens for the wrap report
  modport master (
    output op_valid,
    output op_field,
    output op_dir,
    input  op_wrap
  );

  // Datapath side applies ops and reports the wrap one cycle later
  modport slave (
    input  op_valid,
    input  op_field,
    input  op_dir,
    output op_wrap
  );
endinterface

// File: rtl/time_update_sched.sv
// rtl/time_update_sched.sv - sequences tick carry cascades and single edits onto the counter op port
module time_update_sched #(
  parameter int FIELD_W   = 3,
  parameter int TOP_FIELD = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               en_1,
  input  logic               dem_chinh,
  input  logic [FIELD_W-1:0] select_item,
  input  logic               up,
  input  logic               down,
  time_update_sched_if.master op,
  output logic               busy,
  output logic               year_roll,
  output logic               tick_lost
);

  localparam logic [FIELD_W-1:0] TOP = FIELD_W'(TOP_FIELD);
  localparam logic KIND_TICK = 1'b0;
  localparam logic KIND_EDIT = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state, state_n;
  logic               kind, kind_n;
  logic [FIELD_W-1:0] field, field_n;
  logic               dir, dir_n;
  logic               pend_tick, pend_tick_n;
  logic               pend_edit, pend_edit_n;
  logic [FIELD_W-1:0] pend_field, pend_field_n;
  logic               pend_dir, pend_dir_n;
  logic               op_valid_q, op_valid_n;
  logic               busy_n, year_roll_n, tick_lost_n;

  logic tick_ok, edit_ok, started, tick_used, edit_used;

  assign tick_ok = tick_1hz & en_1;
  assign edit_ok = dem_chinh & (up ^ down) & (select_item <= TOP);

  // Next-state, slot bookkeeping and next registered outputs
  always_comb begin
    state_n      = state;
    kind_n       = kind;
    field_n      = field;
    dir_n        = dir;
    pend_tick_n  = pend_tick;
    pend_edit_n  = pend_edit;
    pend_field_n = pend_field;
    pend_dir_n   = pend_dir;
    tick_lost_n  = tick_lost;
    year_roll_n  = 1'b0;
    started      = 1'b0;
    tick_used    = 1'b0;
    edit_used    = 1'b0;

    case (state)
      IDLE: begin
        // A stale pending tick is dropped if counting was switched off meanwhile
        if (pend_tick) begin
          pend_tick_n = 1'b0;
          if (en_1) begin
            state_n = ISSUE;
            kind_n  = KIND_TICK;
            field_n = '0;
            dir_n   = 1'b0;
            started = 1'b1;
          end
        end
        if (!started && tick_ok) begin
          state_n   = ISSUE;
          kind_n    = KIND_TICK;
          field_n   = '0;
          dir_n     = 1'b0;
          started   = 1'b1;
          tick_used = 1'b1;
        end
        if (!started && pend_edit) begin
          pend_edit_n = 1'b0;
          if (dem_chinh) begin
            state_n = ISSUE;
            kind_n  = KIND_EDIT;
            field_n = pend_field;
            dir_n   = pend_dir;
            started = 1'b1;
          end
        end
        if (!started && edit_ok) begin
          state_n   = ISSUE;
          kind_n    = KIND_EDIT;
          field_n   = select_item;
          dir_n     = down;
          edit_used = 1'b1;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (kind == KIND_TICK && op.op_wrap) begin
          if (field < TOP) begin
            field_n = field + 1'b1;
            state_n = ISSUE;
          end else begin
            year_roll_n = 1'b1;
            state_n     = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Requests not started this cycle park in their one-deep slots
    if (tick_ok && !tick_used) begin
      if (!pend_tick_n) pend_tick_n = 1'b1;
      else              tick_lost_n = 1'b1;
    end
    if (edit_ok && !edit_used && !pend_edit_n) begin
      pend_edit_n  = 1'b1;
      pend_field_n = select_item;
      pend_dir_n   = down;
    end

    op_valid_n = (state_n == ISSUE);
    busy_n     = (state_n != IDLE);
  end

  // State, slots and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kind       <= KIND_TICK;
      field      <= '0;
      dir        <= 1'b0;
      pend_tick  <= 1'b0;
      pend_edit  <= 1'b0;
      pend_field <= '0;
      pend_dir   <= 1'b0;
      op_valid_q <= 1'b0;
      busy       <= 1'b0;
      year_roll  <= 1'b0;
      tick_lost  <= 1'b0;
    end else begin
      state      <= state_n;
      kind       <= kind_n;
      field      <= field_n;
      dir        <= dir_n;
      pend_tick  <= pend_tick_n;
      pend_edit  <= pend_edit_n;
      pend_field <= pend_field_n;
      pend_dir   <= pend_dir_n;
      op_valid_q <= op_valid_n;
      busy       <= busy_n;
      year_roll  <= year_roll_n;
      tick_lost  <= tick_lost_n;
    end
  end

  assign op.op_valid = op_valid_q;
  assign op.op_field = field;
  assign op.op_dir   = dir;

endmodule

// File: tb/tb_time_update_sched.sv
// tb/tb_time_update_sched.sv - self-checking bench for time_update_sched
module tb_time_update_sched;

  logic       clk;
  logic       rst;
  logic       tick_1hz, en_1, dem_chinh, up, down;
  logic [2:0] select_item;
  logic       busy, year_roll, tick_lost;
  logic [7:0] wrap_mask;

  int checks = 0;
  int errors = 0;

  time_update_sched_if #(.FIELD_W(3)) bus ();

  time_update_sched #(.FIELD_W(3), .TOP_FIELD(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .en_1        (en_1),
    .dem_chinh   (dem_chinh),
    .select_item (select_item),
    .up          (up),
    .down        (down),
    .op          (bus),
    .busy        (busy),
    .year_roll   (year_roll),
    .tick_lost   (tick_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath stand-in: fields set in wrap_mask wrap on every op
  always @(posedge clk)
    bus.op_wrap <= !rst && bus.op_valid && wrap_mask[bus.op_field];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Job-level model: each job is a start cycle plus a known number of ops
  int         cyc = 0;
  int         js = -1000, jn = 0, jw = 0;
  logic       jk_edit = 1'b0;
  logic [2:0] jf = '0;
  logic       jd = 1'b0;
  bit         m_pt = 0, m_pe = 0, m_lost = 0;
  logic [2:0] m_pef = '0;
  logic       m_ped = 1'b0;

  task automatic start_tick();
    int w = 0;
    while (w < 6 && wrap_mask[w]) w++;
    jw = w;
    jn = (w == 6) ? 6 : w + 1;
    js = cyc;
    jk_edit = 1'b0;
    jf = '0;
    jd = 1'b0;
  endtask

  task automatic start_edit(input logic [2:0] f, input logic d);
    jw = 0;
    jn = 1;
    js = cyc;
    jk_edit = 1'b1;
    jf = f;
    jd = d;
  endtask

  always @(posedge clk) begin : model
    bit idle_prev, t_ok, e_ok, started, t_used, e_used;
    cyc = cyc + 1;
    if (rst) begin
      js = -1000; jn = 0; jw = 0; jk_edit = 1'b0;
      m_pt = 0; m_pe = 0; m_lost = 0;
    end else begin
      idle_prev = !((cyc - 1) >= js && (cyc - 1) < js + 2 * jn);
      t_ok = tick_1hz && en_1;
      e_ok = dem_chinh && (up != down) && (select_item <= 3'd5);
      started = 0; t_used = 0; e_used = 0;
      if (idle_prev) begin
        if (m_pt) begin
          m_pt = 0;
          if (en_1) begin start_tick(); started = 1; end
        end
        if (!started && t_ok) begin start_tick(); started = 1; t_used = 1; end
        if (!started && m_pe) begin
          m_pe = 0;
          if (dem_chinh) begin start_edit(m_pef, m_ped); started = 1; end
        end
        if (!started && e_ok) begin start_edit(select_item, down); started = 1; e_used = 1; end
      end
      if (t_ok && !t_used) begin
        if (!m_pt) m_pt = 1;
        else m_lost = 1;
      end
      if (e_ok && !e_used && !m_pe) begin
        m_pe = 1; m_pef = select_item; m_ped = down;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the job model
  always @(negedge clk) begin : compare
    bit in_job, e_valid, e_yr;
    int e_field;
    if (cyc > 0) begin
      in_job  = (cyc >= js) && (cyc < js + 2 * jn);
      e_valid = in_job && ((cyc - js) % 2 == 0);
      e_field = jk_edit ? int'(jf) : (cyc - js) / 2;
      e_yr    = !jk_edit && (jw == 6) && (cyc == js + 12);
      chk("m_busy", busy, in_job);
      chk("m_op_valid", bus.op_valid, e_valid);
      chk("m_year_roll", year_roll, e_yr);
      chk("m_tick_lost", tick_lost, m_lost);
      if (e_valid) begin
        chk("m_op_field", bus.op_field, e_field);
        chk("m_op_dir", bus.op_dir, jk_edit ? jd : 1'b0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic t, input logic u, input logic d);
    tick_1hz = t; up = u; down = d;
    step();
    tick_1hz = 1'b0; up = 1'b0; down = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; en_1 = 1'b0; dem_chinh = 1'b0;
    select_item = '0; up = 1'b0; down = 1'b0; wrap_mask = 8'h00;
    repeat (3) step();
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_op_field", bus.op_field, 0);
    chk("rst_busy", busy, 0);
    chk("rst_year_roll", year_roll, 0);
    chk("rst_tick_lost", tick_lost, 0);
    rst = 1'b0;
    repeat (2) step();

    // Single tick, no wrap
    en_1 = 1'b1;
    drive(1, 0, 0);
    chk("t1_op_valid", bus.op_valid, 1);
    chk("t1_op_field", bus.op_field, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_busy_wait", busy, 1);
    chk("t1_no_op_wait", bus.op_valid, 0);
    step();
    chk("t1_idle", busy, 0);
    repeat (2) step();

    // Full six-field cascade ending in year_roll
    wrap_mask = 8'h3F;
    drive(1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      chk("t2_op_valid", bus.op_valid, 1);
      chk("t2_op_field", bus.op_field, k);
      step(); step();
    end
    chk("t2_year_roll", year_roll, 1);
    chk("t2_idle", busy, 0);
    step();
    chk("t2_year_roll_pulse", year_roll, 0);
    repeat (2) step();

    // Pending tick and lost tick
    wrap_mask = 8'h01;
    drive(1, 0, 0);
    step();
    drive(1, 0, 0);
    chk("t3_carry_min", bus.op_field, 1);
    step();
    drive(1, 0, 0);
    chk("t3_tick_lost", tick_lost, 1);
    chk("t3_idle_gap", busy, 0);
    step();
    chk("t3_pend_op", bus.op_valid, 1);
    chk("t3_pend_field", bus.op_field, 0);
    repeat (8) step();
    chk("t3_tick_lost_sticky", tick_lost, 1);

    // Edit down on hour; its wrap must not carry
    en_1 = 1'b0; dem_chinh = 1'b1; wrap_mask = 8'h3F; select_item = 3'd2;
    drive(0, 0, 1);
    chk("t4_op_valid", bus.op_valid, 1);
    chk("t4_op_field", bus.op_field, 2);
    chk("t4_op_dir", bus.op_dir, 1);
    step();
    step();
    chk("t4_no_carry", bus.op_valid, 0);
    chk("t4_idle", busy, 0);
    repeat (3) step();

    // Ignored edits
    select_item = 3'd1;
    drive(0, 1, 1);
    chk("t5_updown_busy", busy, 0);
    select_item = 3'd6;
    drive(0, 1, 0);
    chk("t5_sel6_busy", busy, 0);
    select_item = 3'd7;
    drive(0, 0, 1);
    chk("t5_sel7_valid", bus.op_valid, 0);
    repeat (3) step();

    // Tick and edit together: tick first, edit from the pending slot
    en_1 = 1'b1; wrap_mask = 8'h00; select_item = 3'd3;
    drive(1, 1, 0);
    chk("t7_tick_first", bus.op_field, 0);
    repeat (3) step();
    chk("t7_edit_op", bus.op_valid, 1);
    chk("t7_edit_field", bus.op_field, 3);
    chk("t7_edit_dir", bus.op_dir, 0);
    repeat (3) step();
    // Pending edit discarded when edit mode drops before service
    select_item = 3'd4;
    drive(1, 0, 1);
    dem_chinh = 1'b0;
    repeat (3) step();
    chk("t7_discard_valid", bus.op_valid, 0);
    chk("t7_discard_busy", busy, 0);
    repeat (3) step();

    // Reset during the wait of field 3, with a tick pending
    wrap_mask = 8'h3F;
    drive(1, 0, 0);
    step();
    drive(1, 0, 0);
    repeat (5) step();
    chk("t6_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("t6_op_valid", bus.op_valid, 0);
    chk("t6_op_field", bus.op_field, 0);
    chk("t6_busy", busy, 0);
    chk("t6_tick_lost", tick_lost, 0);
    rst = 1'b0;
    repeat (12) step();
    chk("t6_no_more_ops", bus.op_valid, 0);
    chk("t6_still_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
